rf_write_arbiter: RTL and testbench

- Shares the single write port of the 4x8-bit register file between two independent requesters, A and B.
- Arbitration is round-robin. The block also provides a zero-sweep sequencer that writes 0 to every register, one per cycle, on command.
- All outputs are registered. write_reg, write_data and ctrl_regwrite connect directly to the register file's write port, which is clocked on the same clock.

---
 rtl/rf_write_arbiter_if.sv | 41 ++++
 rtl/rf_write_arbiter.sv | 126 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Write-port bus between the requesters / sweep command and the
// register-file write arbiter.
//   master : requester side (drives req/reg/data, zero_req; sees acks, port)
//   slave  : arbiter side   (samples requests; drives acks, busy, write port)
interface rf_write_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              req_a;
  logic [ADDR_W-1:0] reg_a;
  logic [DATA_W-1:0] data_a;
  logic              ack_a;

  logic              req_b;
  logic [ADDR_W-1:0] reg_b;
  logic [DATA_W-1:0] data_b;
  logic              ack_b;

  logic              zero_req;
  logic              busy;

  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              ctrl_regwrite;

  modport master (
    output req_a, reg_a, data_a,
    output req_b, reg_b, data_b,
    output zero_req,
    input  ack_a, ack_b, busy,
    input  write_reg, write_data, ctrl_regwrite
  );

  modport slave (
    input  req_a, reg_a, data_a,
    input  req_b, reg_b, data_b,
    input  zero_req,
    output ack_a, ack_b, busy,
    output write_reg, write_data, ctrl_regwrite
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// requesters A and B, plus a zero-sweep sequencer that clears every register
// one per cycle on zero_req. All bus outputs are registered.
//   clock : system clock (posedge)
//   clear : synchronous active-high reset
//   bus   : slave side of rf_write_arbiter_if (requests in; acks, busy and
//           the write port out)
module rf_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic             clock,
  input  logic             clear,
  rf_write_arbiter_if.slave bus
);

  typedef enum logic {ST_ARB, ST_SWEEP} state_t;
  typedef enum logic {PTR_A, PTR_B}     ptr_t;

  state_t            state_q, state_d;
  ptr_t              ptr_q,   ptr_d;
  logic [ADDR_W-1:0] cnt_q,   cnt_d;

  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic              busy_q,  busy_d;
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] wreg_q,  wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              elig_a, elig_b;
  logic              grant_a, grant_b;

  always_comb begin
    // A request whose ack is currently showing is the one just served;
    // masking it stops a held request from being granted twice.
    elig_a  = bus.req_a & ~ack_a_q;
    elig_b  = bus.req_b & ~ack_b_q;
    grant_a = elig_a & (~elig_b | (ptr_q == PTR_A));
    grant_b = elig_b & ~grant_a;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    busy_d  = 1'b0;
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;

    unique case (state_q)
      ST_ARB: begin
        if (bus.zero_req) begin
          // First sweep write (register 0) goes out on the entry edge.
          state_d = ST_SWEEP;
          we_d    = 1'b1;
          busy_d  = 1'b1;
          wreg_d  = '0;
          wdata_d = '0;
          cnt_d   = ADDR_W'(1);
        end else if (grant_a) begin
          we_d    = 1'b1;
          ack_a_d = 1'b1;
          wreg_d  = bus.reg_a;
          wdata_d = bus.data_a;
          ptr_d   = PTR_B;
        end else if (grant_b) begin
          we_d    = 1'b1;
          ack_b_d = 1'b1;
          wreg_d  = bus.reg_b;
          wdata_d = bus.data_b;
          ptr_d   = PTR_A;
        end
      end

      ST_SWEEP: begin
        we_d    = 1'b1;
        busy_d  = 1'b1;
        wreg_d  = cnt_q;
        wdata_d = '0;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) begin
          state_d = ST_ARB;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_ARB;
      ptr_q   <= PTR_A;
      cnt_q   <= '0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.ack_a         = ack_a_q;
  assign bus.ack_b         = ack_b_q;
  assign bus.busy          = busy_q;
  assign bus.ctrl_regwrite = we_q;
  assign bus.write_reg     = wreg_q;
  assign bus.write_data    = wdata_q;

  ack_sanity: assert property (@(posedge clock) disable iff (clear)
    !(ack_a_q && ack_b_q) && (!(ack_a_q || ack_b_q) || we_q));

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int NREG   = 1 << ADDR_W;

  logic clock = 1'b0;
  logic clear;

  rf_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Register file attached to the write port.
  logic [DATA_W-1:0] rf [NREG];
  always @(posedge clock) begin
    if (bus.ctrl_regwrite === 1'b1) rf[bus.write_reg] <= bus.write_data;
  end

  int n_checks = 0;
  int n_bad    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: outputs expected after the next edge.
  bit m_we, m_ack_a, m_ack_b, m_busy;
  int m_wreg, m_wdata;
  int pref;          // 0: A wins a tie, 1: B wins a tie
  int sweep_q[$];    // registers still to be swept
  int exp_rf [NREG];

  task automatic model_edge();
    bit ea, eb;
    int g;
    if (m_we) exp_rf[m_wreg] = m_wdata;
    ea = (bus.req_a === 1'b1) && !m_ack_a;
    eb = (bus.req_b === 1'b1) && !m_ack_b;
    m_we = 0; m_ack_a = 0; m_ack_b = 0; m_busy = 0;
    if (clear === 1'b1) begin
      m_wreg = 0; m_wdata = 0; pref = 0;
      sweep_q.delete();
      return;
    end
    if (sweep_q.size() > 0) begin
      m_we = 1; m_busy = 1; m_wdata = 0;
      m_wreg = sweep_q.pop_front();
    end else if (bus.zero_req === 1'b1) begin
      m_we = 1; m_busy = 1; m_wdata = 0; m_wreg = 0;
      for (int r = 1; r < NREG; r++) sweep_q.push_back(r);
    end else begin
      g = -1;
      if (ea && eb) g = pref;
      else if (ea) g = 0;
      else if (eb) g = 1;
      if (g == 0) begin
        m_we = 1; m_ack_a = 1; m_wreg = int'(bus.reg_a); m_wdata = int'(bus.data_a);
        pref = 1;
      end else if (g == 1) begin
        m_we = 1; m_ack_b = 1; m_wreg = int'(bus.reg_b); m_wdata = int'(bus.data_b);
        pref = 0;
      end
    end
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    chk("regwrite",   32'(bus.ctrl_regwrite), 32'(m_we));
    chk("ack_a",      32'(bus.ack_a),         32'(m_ack_a));
    chk("ack_b",      32'(bus.ack_b),         32'(m_ack_b));
    chk("busy",       32'(bus.busy),          32'(m_busy));
    chk("write_reg",  32'(bus.write_reg),     32'(m_wreg));
    chk("write_data", 32'(bus.write_data),    32'(m_wdata));
    @(negedge clock);
  endtask

  task automatic set_idle();
    bus.req_a = 0; bus.reg_a = '0; bus.data_a = '0;
    bus.req_b = 0; bus.reg_b = '0; bus.data_b = '0;
    bus.zero_req = 0;
  endtask

  initial begin
    set_idle();
    clear = 1;
    m_we = 0; m_ack_a = 0; m_ack_b = 0; m_busy = 0;
    m_wreg = 0; m_wdata = 0; pref = 0;
    for (int r = 0; r < NREG; r++) exp_rf[r] = 0;
    @(negedge clock);

    // Reset, then idle.
    step();
    clear = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_we", 32'(bus.ctrl_regwrite), 32'd0);
    end

    // A alone writes reg 2.
    bus.req_a = 1; bus.reg_a = 2'd2; bus.data_a = 8'h5A;
    step();
    chk("a_ack", 32'(bus.ack_a), 32'd1);
    chk("a_reg", 32'(bus.write_reg), 32'd2);
    chk("a_data", 32'(bus.write_data), 32'h5A);
    bus.req_a = 0;
    step();
    chk("rf2_a", 32'(rf[2]), 32'h5A);

    // B alone writes reg 3.
    bus.req_b = 1; bus.reg_b = 2'd3; bus.data_b = 8'h33;
    step();
    bus.req_b = 0;
    step();
    chk("rf3_b", 32'(rf[3]), 32'h33);

    // Sweep aborted by clear after the reg1 write.
    bus.zero_req = 1;
    step();
    chk("sw0_reg", 32'(bus.write_reg), 32'd0);
    chk("sw0_busy", 32'(bus.busy), 32'd1);
    bus.zero_req = 0;
    step();
    chk("sw1_reg", 32'(bus.write_reg), 32'd1);
    clear = 1;
    step();
    chk("abort_we", 32'(bus.ctrl_regwrite), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    clear = 0;
    step();
    step();
    chk("abort_rf0", 32'(rf[0]), 32'd0);
    chk("abort_rf1", 32'(rf[1]), 32'd0);
    chk("abort_rf2", 32'(rf[2]), 32'h5A);
    chk("abort_rf3", 32'(rf[3]), 32'h33);

    // Both saturated: strict A,B alternation from the reset pointer.
    bus.req_a = 1; bus.reg_a = ADDR_W'($urandom); bus.data_a = DATA_W'($urandom);
    bus.req_b = 1; bus.reg_b = ADDR_W'($urandom); bus.data_b = DATA_W'($urandom);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("alt_a", 32'(bus.ack_a), 32'(i % 2 == 0));
      chk("alt_b", 32'(bus.ack_b), 32'(i % 2 == 1));
      if (m_ack_a) begin bus.reg_a = ADDR_W'($urandom); bus.data_a = DATA_W'($urandom); end
      if (m_ack_b) begin bus.reg_b = ADDR_W'($urandom); bus.data_b = DATA_W'($urandom); end
    end
    set_idle();
    step();
    step();

    // Sweep entered while B is pending; B granted at E4.
    bus.req_b = 1; bus.reg_b = 2'd1; bus.data_b = 8'h77;
    bus.zero_req = 1;
    step();
    chk("swb0_reg", 32'(bus.write_reg), 32'd0);
    chk("swb0_ackb", 32'(bus.ack_b), 32'd0);
    bus.zero_req = 0;
    for (int k = 1; k < NREG; k++) begin
      step();
      chk("swb_reg", 32'(bus.write_reg), 32'(k));
      chk("swb_busy", 32'(bus.busy), 32'd1);
      chk("swb_data", 32'(bus.write_data), 32'd0);
    end
    step();
    chk("e4_ackb", 32'(bus.ack_b), 32'd1);
    chk("e4_busy", 32'(bus.busy), 32'd0);
    chk("e4_data", 32'(bus.write_data), 32'h77);
    bus.req_b = 0;
    step();

    // Re-arm: second A write appears two cycles after the first.
    bus.req_a = 1; bus.reg_a = 2'd0; bus.data_a = 8'h42;
    step();
    chk("rearm1_ack", 32'(bus.ack_a), 32'd1);
    bus.reg_a = 2'd3; bus.data_a = 8'hFF;
    step();
    chk("rearm_gap_we", 32'(bus.ctrl_regwrite), 32'd0);
    step();
    chk("rearm2_ack", 32'(bus.ack_a), 32'd1);
    chk("rearm2_reg", 32'(bus.write_reg), 32'd3);
    chk("rearm2_data", 32'(bus.write_data), 32'hFF);
    bus.req_a = 0;
    step();

    // Same-register race with the pointer at B.
    bus.req_a = 1; bus.reg_a = 2'd1; bus.data_a = 8'h11;
    bus.req_b = 1; bus.reg_b = 2'd1; bus.data_b = 8'h22;
    step();
    chk("race_first_b", 32'(bus.ack_b), 32'd1);
    bus.req_b = 0;
    step();
    chk("race_second_a", 32'(bus.ack_a), 32'd1);
    bus.req_a = 0;
    step();
    step();
    chk("race_rf1", 32'(rf[1]), 32'h11);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      if (bus.req_a !== 1'b1) begin
        if ($urandom_range(0, 1) == 1) begin
          bus.req_a = 1; bus.reg_a = ADDR_W'($urandom); bus.data_a = DATA_W'($urandom);
        end
      end else if (m_ack_a) begin
        if ($urandom_range(0, 2) == 0) bus.req_a = 0;
        else begin bus.reg_a = ADDR_W'($urandom); bus.data_a = DATA_W'($urandom); end
      end
      if (bus.req_b !== 1'b1) begin
        if ($urandom_range(0, 1) == 1) begin
          bus.req_b = 1; bus.reg_b = ADDR_W'($urandom); bus.data_b = DATA_W'($urandom);
        end
      end else if (m_ack_b) begin
        if ($urandom_range(0, 2) == 0) bus.req_b = 0;
        else begin bus.reg_b = ADDR_W'($urandom); bus.data_b = DATA_W'($urandom); end
      end
      bus.zero_req = ($urandom_range(0, 19) == 0);
      clear = ($urandom_range(0, 99) == 0);
      step();
    end
    clear = 0;
    set_idle();
    for (int i = 0; i < 6; i++) step();
    for (int r = 0; r < NREG; r++) chk("final_rf", 32'(rf[r]), 32'(exp_rf[r]));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
